skew_register_array: RTL and testbench

- Parametrised multi-lane register pipeline with a per-lane programmable depth.
- Each lane carries a valid bit, and the whole array has global stall (enable) and flush controls.
- Used at the edges of the GEMM systolic array: MODE 0 skews operand rows into the array (lane i delayed i steps), and MODE 1 deskews result columns coming out of it.
- Replaces fixed single-stage flip-flop arrays wherever per-lane latency differs.

---
 rtl/skew_register_array.sv | 69 ++++++
 tb/tb_skew_register_array.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/skew_register_array.sv
// Multi-lane valid/data pipeline; lane i has BASE_DELAY+STEP*i stages (MODE 0) or mirrored (MODE 1).
// Latency L(i) cycles, stretched by stall cycles; enable=0 freezes every stage, flush drops all valid bits.
module skew_register_array #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM        = 4,
   parameter int BASE_DELAY = 1,
   parameter int STEP       = 1,
   parameter int MODE       = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           flush,
   input  logic [NUM-1:0]                 valid_in,
   input  logic [NUM-1:0][DATA_WIDTH-1:0] data_in,
   output logic [NUM-1:0]                 valid_out,
   output logic [NUM-1:0][DATA_WIDTH-1:0] data_out,
   output logic                           empty
);

   if (BASE_DELAY < 1 || STEP < 0) begin : g_param_err
      $error("skew_register_array: BASE_DELAY must be >= 1 and STEP >= 0");
   end

   logic [NUM-1:0] lane_busy;

   for (genvar i = 0; i < NUM; i++) begin : g_lane
      localparam int DEPTH = (MODE == 0) ? BASE_DELAY + STEP * i
                                         : BASE_DELAY + STEP * (NUM - 1 - i);

      logic [DEPTH-1:0]                 stage_vld;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_dat;
      logic [DEPTH-1:0]                 src_vld;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] src_dat;

      always_comb begin
         src_vld    = '0;
         src_dat    = '0;
         src_vld[0] = valid_in[i];
         src_dat[0] = data_in[i];
         for (int k = 1; k < DEPTH; k++) begin
            src_vld[k] = stage_vld[k-1];
            src_dat[k] = stage_dat[k-1];
         end
      end

      // Data only moves behind a valid bit, so data_out keeps the last word that left the lane.
      always_ff @(posedge clk) begin
         if (!rst) begin
            stage_vld <= '0;
            stage_dat <= '0;
         end else if (flush) begin
            stage_vld <= '0;
         end else if (enable) begin
            stage_vld <= src_vld;
            for (int k = 0; k < DEPTH; k++) begin
               if (src_vld[k]) stage_dat[k] <= src_dat[k];
            end
         end
      end

      assign valid_out[i] = stage_vld[DEPTH-1];
      assign data_out[i]  = stage_dat[DEPTH-1];
      assign lane_busy[i] = |stage_vld;
   end

   assign empty = ~|lane_busy;

endmodule

// File: tb/tb_skew_register_array.sv
// Drives a skew (MODE 0) and a deskew (MODE 1) instance with the same stimulus;
// a cycle-stamped scoreboard holds the words each lane must present and when.
module tb_skew_register_array;
   localparam int DW = 32;
   localparam int N  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, enable, flush;
   logic [N-1:0]           valid_in;
   logic [N-1:0][DW-1:0]   data_in;
   logic [N-1:0]           vo_sk, vo_dk;
   logic [N-1:0][DW-1:0]   do_sk, do_dk;
   logic                   em_sk, em_dk;

   skew_register_array #(.DATA_WIDTH(DW), .NUM(N), .BASE_DELAY(1), .STEP(1), .MODE(0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(vo_sk), .data_out(do_sk), .empty(em_sk));

   skew_register_array #(.DATA_WIDTH(DW), .NUM(N), .BASE_DELAY(1), .STEP(1), .MODE(1)) dut_dk (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(vo_dk), .data_out(do_dk), .empty(em_dk));

   typedef struct {
      int          cyc;
      int          unit;
      int          lane;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_vec   = 0;
   int   n_miss  = 0;
   bit   rst_seen = 1'b0;

   function automatic int lat(int unit, int lane);
      return (unit == 0) ? 1 + lane : 1 + (N - 1 - lane);
   endfunction

   task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      logic [N-1:0]         ev;
      logic [N-1:0]         vo;
      logic [N-1:0][DW-1:0] dout;
      logic                 em;
      bit                   busy;
      @(posedge clk);
      #1;
      cyc++;
      for (int u = 0; u < 2; u++) begin
         vo   = (u == 0) ? vo_sk : vo_dk;
         dout = (u == 0) ? do_sk : do_dk;
         em   = (u == 0) ? em_sk : em_dk;
         ev   = '0;
         busy = 1'b0;
         foreach (sb[k]) begin
            if (sb[k].unit == u) begin
               if (sb[k].cyc == cyc) begin
                  ev[sb[k].lane] = 1'b1;
                  check($sformatf("u%0d lane%0d data", u, sb[k].lane), dout[sb[k].lane], sb[k].dat);
               end
               if (sb[k].cyc >= cyc) busy = 1'b1;
            end
         end
         check($sformatf("u%0d valid_out", u), DW'(vo), DW'(ev));
         check($sformatf("u%0d empty", u), DW'(em), DW'(!busy));
         if (rst_seen) begin
            for (int i = 0; i < N; i++)
               check($sformatf("u%0d lane%0d reset data", u, i), dout[i], '0);
         end
      end
      for (int k = sb.size() - 1; k >= 0; k--)
         if (sb[k].cyc < cyc) sb.delete(k);
      rst_seen = 1'b0;
   endtask

   // Applies one cycle of inputs, updates the expectation queue, then advances a clock.
   task automatic drive(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] d,
                        input logic en, input logic fl, input logic rs);
      int   c;
      int   n;
      exp_t e;
      valid_in = v;
      data_in  = d;
      enable   = en;
      flush    = fl;
      rst      = rs;
      c = cyc;
      if (!rs || fl) begin
         for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].cyc > c) sb.delete(k);
         if (!rs) rst_seen = 1'b1;
      end else if (!en) begin
         n = sb.size();
         for (int k = 0; k < n; k++) begin
            if (sb[k].cyc > c) sb[k].cyc++;
            else if (sb[k].cyc == c) begin
               e = sb[k];
               e.cyc = c + 1;
               sb.push_back(e);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (v[i]) begin
               for (int u = 0; u < 2; u++) begin
                  e.cyc  = c + lat(u, i);
                  e.unit = u;
                  e.lane = i;
                  e.dat  = d[i];
                  sb.push_back(e);
               end
            end
         end
      end
      tick();
   endtask

   task automatic idle(int n);
      repeat (n) drive('0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   logic [N-1:0][DW-1:0] wf, bk, junk, ffd, rnd;

   initial begin
      wf   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      bk   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      junk = {32'hEE, 32'hEE, 32'hEE, 32'hEE};
      ffd  = {32'h0, 32'h0, 32'h0, 32'hFF};

      // Reset with random inputs
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) rnd[i] = $urandom;
         drive(N'($urandom), rnd, 1'($urandom), 1'b0, 1'b0);
      end
      idle(1);
      for (int i = 0; i < N; i++) begin
         check($sformatf("post-reset sk lane%0d data", i), do_sk[i], '0);
         check($sformatf("post-reset dk lane%0d data", i), do_dk[i], '0);
      end

      // Skew wavefront
      drive(4'hF, wf, 1'b1, 1'b0, 1'b1);
      idle(6);
      for (int i = 0; i < N; i++) begin
         check($sformatf("hold sk lane%0d", i), do_sk[i], wf[i]);
         check($sformatf("hold dk lane%0d", i), do_dk[i], wf[i]);
      end

      // Stall for three edges; inputs during the stall must be ignored
      drive(4'hF, wf, 1'b1, 1'b0, 1'b1);
      drive('0, '0, 1'b1, 1'b0, 1'b1);
      repeat (3) drive(4'hF, junk, 1'b0, 1'b0, 1'b1);
      idle(6);

      // Flush with a simultaneous input word that must be discarded
      drive(4'hF, wf, 1'b1, 1'b0, 1'b1);
      drive('0, '0, 1'b1, 1'b0, 1'b1);
      drive(4'b0001, ffd, 1'b1, 1'b1, 1'b1);
      idle(5);
      check("flush keeps sk lane0 data", do_sk[0], 32'hA0);

      // Deskew: lane i fed alone in cycle i
      for (int i = 0; i < N; i++) drive(N'(1 << i), bk, 1'b1, 1'b0, 1'b1);
      idle(6);

      // Reset mid-flight, then normal traffic again
      drive(4'hF, wf, 1'b1, 1'b0, 1'b1);
      drive('0, '0, 1'b1, 1'b0, 1'b1);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      drive(4'hF, wf, 1'b1, 1'b0, 1'b1);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
